// File: rtl/display_scan_driver.sv
// Binary-to-BCD (sequential double-dabble) feeder for a 4-digit 7-segment display,
// with a free-running digit scanner whose enables lag the nibble bus by one cycle.
module display_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  anode_n
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_shift;
    logic [15:0] r_bcd;
    logic [15:0] r_value;
    logic [15:0] r_shadow;
    logic [15:0] w_adj;
    logic [15:0] w_shadow;
    logic        w_lead;

    logic [PW-1:0] r_presc;
    logic          w_tc;
    logic [1:0]    r_slot;
    logic [1:0]    r_slot_d;
    logic [3:0]    r_nibble;
    logic [3:0]    r_anode;

    assign busy         = (r_state != S_IDLE);
    assign digit_nibble = r_nibble;
    assign anode_n      = r_anode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_next = S_CONV;
            S_CONV:  if (r_cnt == 4'd15) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Blank from the most significant digit down until the first nonzero; digit 0 always shown.
    always_comb begin
        w_shadow = r_bcd;
        w_lead   = 1'b1;
        if (r_value > 16'd9999) begin
            w_shadow = 16'hEEEE;
        end else if (BLANK_LEADING) begin
            for (int unsigned i = 3; i >= 1; i--) begin
                if (w_lead && (r_bcd[4*i +: 4] == 4'h0)) begin
                    w_shadow[4*i +: 4] = 4'hF;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_bcd    <= '0;
            r_value  <= '0;
            r_shadow <= 16'hFFF0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_value <= value_in;
                        r_shift <= value_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CONV: begin
                    r_bcd   <= {w_adj[14:0], r_shift[15]};
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                end
                S_FIN: begin
                    r_shadow <= w_shadow;
                end
                default: ;
            endcase
        end
    end

    assign w_tc = (r_presc == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_slot   <= '0;
            r_slot_d <= '0;
            r_nibble <= 4'hF;
            r_anode  <= 4'hF;
        end else begin
            r_presc  <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc) r_slot <= r_slot + 2'd1;
            r_nibble <= r_shadow[{r_slot, 2'b00} +: 4];
            r_slot_d <= r_slot;
            r_anode  <= ~(4'b0001 << r_slot_d);
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench: table of load values with expected digits for both blanking modes,
// plus sequences for load-while-busy, load at FIN and reset mid-conversion.
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic        busy, busy_nb;
    logic [3:0]  nib, an, nib_nb, an_nb;

    int checks = 0;
    int errors = 0;
    logic [15:0] cur_e, cur_enb;

    typedef struct {
        logic [15:0] v;
        logic [15:0] e;
        logic [15:0] enb;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .busy(busy), .digit_nibble(nib), .anode_n(an)
    );

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .busy(busy_nb), .digit_nibble(nib_nb), .anode_n(an_nb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // anode at this sample must select the digit that was on the nibble bus one sample earlier
    function automatic bit pair_ok(input logic [3:0] a, input logic [3:0] p, input logic [15:0] e);
        case (a)
            4'hE:    return p == e[3:0];
            4'hD:    return p == e[7:4];
            4'hB:    return p == e[11:8];
            4'h7:    return p == e[15:12];
            default: return 1'b0;
        endcase
    endfunction

    task automatic scan_check(input string name, input logic [15:0] e, input logic [15:0] enb);
        int bad = 0;
        int bad_nb = 0;
        logic [3:0] p, pn, seen;
        p = nib;
        pn = nib_nb;
        seen = 4'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!pair_ok(an, p, e)) bad++;
            if (!pair_ok(an_nb, pn, enb)) bad_nb++;
            seen = seen | ~an;
            p = nib;
            pn = nib_nb;
        end
        chk({name, "_scan"}, bad, 0);
        chk({name, "_scan_nb"}, bad_nb, 0);
        chk({name, "_slots"}, {28'd0, seen}, 32'hF);
    endtask

    task automatic do_load(input string name, input logic [15:0] v, input int inj_at,
                           input logic [15:0] e, input logic [15:0] enb);
        int n = 0;
        int hold_bad = 0;
        logic [3:0] p, pn;
        p = nib;
        pn = nib_nb;
        value_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value_in = ~v;
        while (busy && n < 40) begin
            n++;
            if (!pair_ok(an, p, cur_e)) hold_bad++;
            if (!pair_ok(an_nb, pn, cur_enb)) hold_bad++;
            p = nib;
            pn = nib_nb;
            if (n == inj_at) begin
                load = 1'b1;
                value_in = 16'd5678;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk({name, "_busy_len"}, n, 17);
        chk({name, "_hold"}, hold_bad, 0);
        @(negedge clk);
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
        cur_e = e;
        cur_enb = enb;
        scan_check(name, e, enb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cad_bad;
        logic [3:0] a0;
        logic [1:0] s;

        tbl[0] = '{16'd1234,  16'h1234, 16'h1234};
        tbl[1] = '{16'd7,     16'hFFF7, 16'h0007};
        tbl[2] = '{16'd0,     16'hFFF0, 16'h0000};
        tbl[3] = '{16'd10000, 16'hEEEE, 16'hEEEE};
        tbl[4] = '{16'd65535, 16'hEEEE, 16'hEEEE};
        tbl[5] = '{16'd9999,  16'h9999, 16'h9999};
        tbl[6] = '{16'd100,   16'hF100, 16'h0100};
        tbl[7] = '{16'd1005,  16'h1005, 16'h1005};
        tbl[8] = '{16'd50,    16'hFF50, 16'h0050};

        rst_n = 1'b0;
        load = 1'b0;
        value_in = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_anode", {28'd0, an}, 32'hF);
        chk("rst_nibble", {28'd0, nib}, 32'hF);
        chk("rst_nibble_nb", {28'd0, nib_nb}, 32'hF);
        rst_n = 1'b1;

        // scan cadence: each slot held REFRESH_DIV cycles, slots ascending
        @(negedge clk);
        a0 = an;
        n = 0;
        while (an == a0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("cad_wait", {31'd0, (n < 20)}, 32'd1);
        case (an)
            4'hE: s = 2'd0;
            4'hD: s = 2'd1;
            4'hB: s = 2'd2;
            default: s = 2'd3;
        endcase
        cad_bad = 0;
        for (int k = 0; k < 16; k++) begin
            logic [1:0] es;
            es = s + 2'(k / 4);
            if (an !== ~(4'b0001 << es)) cad_bad++;
            @(negedge clk);
        end
        chk("cadence", cad_bad, 0);

        cur_e = 16'hFFF0;
        cur_enb = 16'hFFF0;
        scan_check("rst", 16'hFFF0, 16'hFFF0);

        for (int i = 0; i < 9; i++) begin
            do_load($sformatf("vec%0d", i), tbl[i].v, 0, tbl[i].e, tbl[i].enb);
        end

        do_load("ign_busy", 16'd1234, 5, 16'h1234, 16'h1234);
        do_load("ign_fin", 16'd7, 17, 16'hFFF7, 16'h0007);

        value_in = 16'd1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_anode", {28'd0, an}, 32'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cur_e = 16'hFFF0;
        cur_enb = 16'hFFF0;
        scan_check("abort", 16'hFFF0, 16'hFFF0);
        do_load("after_abort", 16'd42, 0, 16'hFF42, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
